// File: rtl/perf_event_dumper_pkg.sv
// Shared types and default parameters for perf_event_dumper.
package perf_pkg;

    localparam int unsigned PerfNumSrc     = 8;
    localparam int unsigned PerfCntW       = 32;
    localparam int unsigned PerfDumpPeriod = 1024;

    // Widest id/count a record can carry; narrower builds zero-extend into it.
    localparam int unsigned PerfIdMaxW  = 8;
    localparam int unsigned PerfCntMaxW = 64;

    typedef enum logic {PERF_IDLE, PERF_DUMP} perf_state_t;

    typedef struct packed {
        logic [PerfIdMaxW-1:0]  id;
        logic [PerfCntMaxW-1:0] count;
        logic                   last;
    } perf_record_t;

endpackage

// File: rtl/perf_event_dumper_if.sv
// Record stream from the dumper to the shared log/difftest sink.
interface perf_event_dumper_if #(
    parameter int unsigned ID_W  = 3,
    parameter int unsigned CNT_W = 32
);
    logic             out_valid;
    logic             out_ready;
    logic [ID_W-1:0]  out_id;
    logic [CNT_W-1:0] out_count;
    logic             out_last;

    modport master (output out_valid, out_id, out_count, out_last, input out_ready);
    modport slave  (input out_valid, out_id, out_count, out_last, output out_ready);
endinterface

// File: rtl/perf_event_dumper_counter.sv
// One event counter slot with clear-on-load; PERF_SATURATE_EN makes increments saturate.
module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d, sum;

    always_comb begin
`ifdef PERF_SATURATE_EN
        sum = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(inc);
`else
        sum = cnt_q + CNT_W'(inc);
`endif
        // A load snapshots the old value; the same-cycle event seeds the cleared counter.
        cnt_d = load ? CNT_W'(inc) : sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/perf_event_dumper.sv
// Per-source perf event counters drained serially to one record stream, periodically or on
// request. Build with PERF_SATURATE_EN to saturate counters instead of wrapping.
module perf_event_dumper
    import perf_pkg::*;
#(
    parameter int unsigned NUM_SRC     = PerfNumSrc,
    parameter int unsigned CNT_W       = PerfCntW,
    parameter int unsigned DUMP_PERIOD = PerfDumpPeriod,
    parameter int unsigned ID_W        = $clog2(NUM_SRC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_SRC-1:0]  event_i,
    input  logic                dump_req,
    perf_event_dumper_if.master out,
    output logic                busy,
    output logic [63:0]         cycle_cnt
);
    localparam int unsigned TMR_W = $clog2(DUMP_PERIOD);

    perf_state_t      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pending_q, pending_d;
    logic             valid_q, valid_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      cycle_q;

    logic             load_en;
    logic [ID_W-1:0]  load_idx;
    logic [CNT_W-1:0] cnt [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt
        perf_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (en && event_i[i]),
            .load(load_en && (load_idx == ID_W'(i))),
            .cnt (cnt[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        valid_d   = valid_q;
        id_d      = id_q;
        count_d   = count_q;
        load_en   = 1'b0;
        load_idx  = '0;

        unique case (state_q)
            PERF_IDLE: begin
                // Timer expiry, a fresh request and a deferred request all merge into one round.
                if (timer_q == '0 || dump_req || pending_q) begin
                    state_d   = PERF_DUMP;
                    timer_d   = TMR_W'(DUMP_PERIOD - 1);
                    pending_d = 1'b0;
                    load_en   = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            PERF_DUMP: begin
                if (dump_req) pending_d = 1'b1;
                if (valid_q && out.out_ready) begin
                    if (id_q < ID_W'(NUM_SRC - 1)) begin
                        load_en  = 1'b1;
                        load_idx = id_q + ID_W'(1);
                    end else begin
                        valid_d = 1'b0;
                        state_d = PERF_IDLE;
                    end
                end
            end
        endcase

        if (load_en) begin
            valid_d = 1'b1;
            id_d    = load_idx;
            count_d = cnt[load_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PERF_IDLE;
            timer_q   <= TMR_W'(DUMP_PERIOD - 1);
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            count_q   <= '0;
            cycle_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            count_q   <= count_d;
            cycle_q   <= cycle_q + 64'd1;
        end
    end

    assign out.out_valid = valid_q;
    assign out.out_id    = id_q;
    assign out.out_count = count_q;
    assign out.out_last  = valid_q && (id_q == ID_W'(NUM_SRC - 1));
    assign busy          = (state_q == PERF_DUMP);
    assign cycle_cnt     = cycle_q;
endmodule

// File: tb/tb_perf_event_dumper.sv
// Directed bench for perf_event_dumper with NUM_SRC=4, CNT_W=8, DUMP_PERIOD=16.
module tb_perf_event_dumper;
    import perf_pkg::*;

    localparam int unsigned NS  = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned DP  = 16;
    localparam int unsigned IW  = 2;

`ifdef PERF_SATURATE_EN
    localparam logic [7:0] SAT_EXP = 8'd255;
`else
    localparam logic [7:0] SAT_EXP = 8'd44;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [NS-1:0] event_i;
    logic          dump_req;
    logic          busy;
    logic [63:0]   cycle_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    perf_event_dumper_if #(.ID_W(IW), .CNT_W(CW)) bus ();

    perf_event_dumper #(
        .NUM_SRC    (NS),
        .CNT_W      (CW),
        .DUMP_PERIOD(DP),
        .ID_W       (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .event_i  (event_i),
        .dump_req (dump_req),
        .out      (bus),
        .busy     (busy),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!bus.out_valid && k < 40) begin
            tick();
            k++;
        end
        check({tag, " valid"}, 64'(bus.out_valid), 64'd1);
    endtask

    // Called at the negedge showing record 0; req_mask pulses dump_req while record i is shown.
    task automatic collect_round(input string tag, input logic [4*8-1:0] exp,
                                 input logic [3:0] req_mask);
        perf_record_t e;
        for (int i = 0; i < 4; i++) begin
            e.id    = PerfIdMaxW'(i);
            e.count = PerfCntMaxW'(exp[i*8 +: 8]);
            e.last  = (i == 3);
            check($sformatf("%s id%0d", tag, i), 64'(bus.out_id), 64'(e.id));
            check($sformatf("%s count%0d", tag, i), 64'(bus.out_count), e.count);
            check($sformatf("%s last%0d", tag, i), 64'(bus.out_last), 64'(e.last));
            dump_req = req_mask[i];
            tick();
        end
        dump_req = 1'b0;
        check({tag, " busy end"}, 64'(busy), 64'd0);
        check({tag, " valid end"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int saw;
        rst           = 1'b1;
        en            = 1'b1;
        event_i       = '0;
        dump_req      = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst valid", 64'(bus.out_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst cycle", cycle_cnt, 64'd0);
        check("rst id", 64'(bus.out_id), 64'd0);
        check("rst count", 64'(bus.out_count), 64'd0);
        check("rst last", 64'(bus.out_last), 64'd0);

        // Idle: timer expires on the 16th cycle out of reset.
        rst = 1'b0;
        repeat (15) tick();
        check("t1 early valid", 64'(bus.out_valid), 64'd0);
        check("t1 cycle15", cycle_cnt, 64'd15);
        tick();
        check("t1 valid", 64'(bus.out_valid), 64'd1);
        check("t1 cycle16", cycle_cnt, 64'd16);
        collect_round("t1", {8'd0, 8'd0, 8'd0, 8'd0}, 4'b0000);

        // Five events on source 2, then an explicit request.
        event_i = 4'b0100;
        repeat (5) tick();
        event_i  = '0;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        check("t2 valid", 64'(bus.out_valid), 64'd1);
        collect_round("t2", {8'd0, 8'd5, 8'd0, 8'd0}, 4'b0000);
        wait_valid("t2b");
        collect_round("t2b", {8'd0, 8'd0, 8'd0, 8'd0}, 4'b0000);

        // Backpressure on record 1 while source 1 pulses three times.
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        check("t3 valid", 64'(bus.out_valid), 64'd1);
        tick();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            event_i = (c == 2 || c == 5 || c == 8) ? 4'b0010 : 4'b0000;
            tick();
            check($sformatf("t3 hold id c%0d", c), 64'(bus.out_id), 64'd1);
            check($sformatf("t3 hold count c%0d", c), 64'(bus.out_count), 64'd0);
        end
        event_i       = '0;
        bus.out_ready = 1'b1;
        tick();
        check("t3 id2", 64'(bus.out_id), 64'd2);
        tick();
        check("t3 id3", 64'(bus.out_id), 64'd3);
        tick();
        check("t3 busy end", 64'(busy), 64'd0);
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        check("t3b valid", 64'(bus.out_valid), 64'd1);
        collect_round("t3b", {8'd0, 8'd0, 8'd3, 8'd0}, 4'b0000);

        // Two requests while busy collapse into one extra round.
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        check("t4 valid", 64'(bus.out_valid), 64'd1);
        collect_round("t4", {8'd0, 8'd0, 8'd0, 8'd0}, 4'b0110);
        tick();
        check("t4 pend valid", 64'(bus.out_valid), 64'd1);
        check("t4 pend busy", 64'(busy), 64'd1);
        collect_round("t4p", {8'd0, 8'd0, 8'd0, 8'd0}, 4'b0000);
        saw = 0;
        repeat (15) begin
            tick();
            if (bus.out_valid) saw++;
        end
        check("t4 no third round", 64'(saw), 64'd0);
        // Timer is now 0: a coincident request must give exactly one round.
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        check("t4 coinc valid", 64'(bus.out_valid), 64'd1);
        collect_round("t4c", {8'd0, 8'd0, 8'd0, 8'd0}, 4'b0000);
        saw = 0;
        repeat (15) begin
            tick();
            if (bus.out_valid) saw++;
        end
        check("t4 no double", 64'(saw), 64'd0);

        // 300 events on source 0 while the round is held on record 1.
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        event_i       = 4'b0001;
        repeat (300) tick();
        event_i = '0;
        check("t5 held id", 64'(bus.out_id), 64'd1);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("t5 busy end", 64'(busy), 64'd0);
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        check("t5 valid", 64'(bus.out_valid), 64'd1);
        collect_round("t5", {8'd0, 8'd0, 8'd0, SAT_EXP}, 4'b0000);

        // Reset in the middle of a round, then counting disabled.
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        event_i  = 4'b1000;
        tick();
        tick();
        check("t6 id2", 64'(bus.out_id), 64'd2);
        rst     = 1'b1;
        event_i = '0;
        tick();
        check("t6 valid", 64'(bus.out_valid), 64'd0);
        check("t6 busy", 64'(busy), 64'd0);
        check("t6 cycle", cycle_cnt, 64'd0);
        check("t6 id", 64'(bus.out_id), 64'd0);
        rst     = 1'b0;
        en      = 1'b0;
        event_i = 4'hf;
        repeat (3) tick();
        event_i  = '0;
        en       = 1'b1;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        check("t6b valid", 64'(bus.out_valid), 64'd1);
        collect_round("t6b", {8'd0, 8'd0, 8'd0, 8'd0}, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/perf_event_dumper.md
# perf_event_dumper

Collects single-cycle performance event pulses from up to NUM_SRC requesters into private counters. Periodically, or on demand, it serially drains every counter to one shared log/difftest sink over a valid/ready port, clearing each counter as it is read. It sits between the core's scattered perf probes and the single log-event channel, and also supplies the free-running cycle timestamp for log lines.

## Interface
- NUM_SRC, 8, number of event sources (≥2)
- CNT_W, 32, counter and output count width
- DUMP_PERIOD, 1024, cycles between automatic dump rounds (≥NUM_SRC+2)
- ID_W, $clog2(NUM_SRC), derived source-id width
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- en  in  1  global counting enable; gates increments only
- event_i  in  NUM_SRC  per-source event pulse, one count per cycle high
- dump_req  in  1  request an immediate dump round (pulse)
- out_valid  out  1  record valid
- out_ready  in  1  sink accepts record
- out_id  out  ID_W  source index of record
- out_count  out  CNT_W  counter value snapshot
- out_last  out  1  record is final of the round (out_id==NUM_SRC-1)
- busy  out  1  dump round in progress
- cycle_cnt  out  64  free-running cycle counter

## Operation
- Reset: all counters 0, cycle_cnt 0, timer DUMP_PERIOD-1, state IDLE, pending 0, out_valid/out_last/busy 0, out_id/out_count 0.
- Counting: each cycle, cnt[i] += (en && event_i[i]), in IDLE and in DUMP.
- Trigger: in IDLE, a round starts when timer==0 or dump_req==1. The timer decrements only in IDLE and reloads to DUMP_PERIOD-1 when a round starts.
- FSM IDLE -> DUMP on trigger. On entry, load idx 0: out_count<=cnt[0], out_id<=0, out_valid<=1. Clear-on-load sets cnt[0]<=(en&&event_i[0]); a same-cycle event is never lost.
- In DUMP, on out_valid&&out_ready: if out_id<NUM_SRC-1, load out_id+1 the same way. Otherwise out_valid<=0 and the FSM goes to IDLE.
- Held record: while out_valid&&!out_ready, out_id/out_count/out_last are stable. No counter is cleared while a record is held.
- dump_req while busy sets a one-deep pending flag. On return to IDLE with pending=1, a new round starts the next cycle, pending clears, and the timer reloads. Further requests while pending=1 merge into it.
- Simultaneous timer expiry and dump_req in IDLE start a single round.
- Reset mid-round aborts immediately. Partially drained counters are not restored; all state returns to reset values.

## Timing
- Trigger cycle T gives out_valid=1 at T+1.
- With out_ready held high, one record per cycle: records at T+1..T+NUM_SRC, busy 0 at T+NUM_SRC+1.
- Record i's out_count equals the sum of en&&event_i[i] over the cycles since source i was last loaded, excluding the load cycle. Events in the load cycle go to the cleared counter.
- cycle_cnt increments every cycle after reset and wraps at 2^64.
- busy == (state==DUMP). out_last == out_valid && out_id==NUM_SRC-1.

## Configuration
- PERF_SATURATE_EN defined: each counter and increment saturates at 2^CNT_W-1.
- PERF_SATURATE_EN undefined: counters wrap modulo 2^CNT_W.
- Saturation affects only increments. Clear-on-load behaviour is identical in both builds.

## Structure
- Package perf_pkg holds:
  - typedef enum logic {PERF_IDLE, PERF_DUMP} perf_state_t
  - typedef perf_record_t {id, count, last}
  - default parameter constants
- Sub-module perf_counter: one CNT_W counter slot with inc, clear-on-load and the PERF_SATURATE_EN logic. It is instantiated NUM_SRC times by generate.
- Top holds the FSM, timer, pending flag, output registers and cycle_cnt.

## Test plan
All scenarios use NUM_SRC=4, CNT_W=8, DUMP_PERIOD=16.
- Reset then idle with no events, ready=1: first round triggers at cycle 15, giving four records id 0..3 with count 0, and out_last only on id 3.
- event_i[2] high for 5 cycles then dump_req, ready=1: records 0,0,5,0. The next round shows id 2 count 0.
- Backpressure: ready=0 for 10 cycles during record id 1 while event_i[1] pulses 3 times: out_id/out_count stay stable. The following round reports id 1 count 3.
- dump_req twice during busy: exactly one extra round starts on the cycle after the first round ends. Timer expiry is not double-counted.
- Saturation: event_i[0] high 300 cycles, en=1, then dump. With PERF_SATURATE_EN defined, count is 255; without it, count is 300 mod 256 = 44.
- rst asserted mid-round at id 2: the next cycle has out_valid=0, busy=0, cycle_cnt=0 and all counters 0.
